// File: rtl/rv_dm_responder.sv
// rv_dm_responder: word-indexed data-memory responder with fixed wait states,
// byte-lane stores, and an error pulse for out-of-range or conflicting requests.
module rv_dm_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_err_o
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [2:0] WS_M1 = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_t state, state_n;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx_q, rd_idx;
  logic [31:0] wdata_q;
  logic [3:0] sel_q;
  logic [2:0] cnt;
  logic store_q, oor_q, err_q, accept, req_oor, rd_oor, rd_store;
  assign accept = state == IDLE && (dm_load_i || dm_store_i);
  assign req_oor = (dm_addr_i >> (ADDR_WIDTH + 2)) != 32'd0;
  // With no wait states the read happens on the accept edge, so use the live request.
  assign rd_idx = state == IDLE ? dm_addr_i[ADDR_WIDTH+1:2] : idx_q;
  assign rd_oor = state == IDLE ? req_oor : oor_q;
  assign rd_store = state == IDLE ? dm_store_i : store_q;
  always_comb begin
    state_n = state;
    if (accept) state_n = WAIT_STATES == 0 ? DONE : WAIT;
    else if (state == WAIT && cnt == 3'd0) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      idx_q       <= '0;
      wdata_q     <= 32'd0;
      sel_q       <= 4'd0;
      store_q     <= 1'b0;
      oor_q       <= 1'b0;
      err_q       <= 1'b0;
      dm_data_l_o <= 32'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        idx_q   <= dm_addr_i[ADDR_WIDTH+1:2];
        wdata_q <= dm_data_s_i;
        sel_q   <= dm_data_select_i;
        store_q <= dm_store_i;
        oor_q   <= req_oor;
        err_q   <= req_oor || (dm_load_i && dm_store_i);
        cnt     <= WS_M1;
      end else if (state == WAIT) cnt <= cnt - 3'd1;
      if (state_n == DONE && !rd_store) dm_data_l_o <= rd_oor ? 32'd0 : mem[rd_idx];
    end
  end
  // Memory has no reset; a reset during DONE suppresses the commit.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && state == DONE && store_q && !oor_q)
      for (int i = 0; i < 4; i++)
        if (sel_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
  assign dm_ready_o      = state == IDLE;
  assign dm_load_done_o  = state == DONE && !store_q;
  assign dm_store_done_o = state == DONE && store_q;
  assign dm_err_o        = state == DONE && err_q;
endmodule
